// File: rtl/subword_store_rmw.sv
// subword_store_rmw: turns SB/SH stores into a read-modify-write sequence on a
// word-only data memory. SW stores and loads pass through without stalling.
module subword_store_rmw #(
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_memwrite,
    input  logic              ex_mem_memread,
    input  logic [2:0]        ex_mem_funct3,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [31:0]       ex_mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              mem_write_bh,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WRITE
    } state_t;

    // Counter preload: WAIT lasts READ_LATENCY cycles, the last one has cnt==0.
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_lane;
    logic              lat_half;
    logic [15:0]       lat_wdata;
    logic [31:0]       merged;
    logic [1:0]        cnt;

    logic              start;
    logic              is_sb;
    logic              is_sh;
    logic [ADDR_W-1:0] aligned;
    logic [31:0]       merge_word;

    assign is_sb   = (ex_mem_funct3 == 3'b000);
    assign is_sh   = (ex_mem_funct3 == 3'b001);
    assign aligned = {ex_mem_addr[ADDR_W-1:2], 2'b00};

    // Overlay the latched byte/half onto the word coming back from memory.
    always_comb begin
        merge_word = mem_rdata;
        if (lat_half) begin
            if (lat_lane[1]) begin
                merge_word[31:16] = lat_wdata;
            end else begin
                merge_word[15:0] = lat_wdata;
            end
        end else begin
            case (lat_lane)
                2'd0:    merge_word[7:0]   = lat_wdata[7:0];
                2'd1:    merge_word[15:8]  = lat_wdata[7:0];
                2'd2:    merge_word[23:16] = lat_wdata[7:0];
                default: merge_word[31:24] = lat_wdata[7:0];
            endcase
        end
    end

    // Next state and memory-port outputs; everything is held at 0 while in reset.
    always_comb begin
        state_next   = state;
        start        = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_write_bh = 1'b0;
        misalign_err = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (ex_mem_memwrite) begin
                        if (is_sb || (is_sh && !ex_mem_addr[0])) begin
                            start        = 1'b1;
                            mem_re       = 1'b1;
                            mem_addr     = aligned;
                            mem_write_bh = 1'b1;
                            state_next   = ST_WAIT;
                        end else if (is_sh) begin
                            misalign_err = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_addr  = aligned;
                            mem_wdata = ex_mem_wdata;
                        end
                    end else if (ex_mem_memread) begin
                        mem_re   = 1'b1;
                        mem_addr = aligned;
                    end
                end
                ST_WAIT: begin
                    mem_write_bh = 1'b1;
                    mem_addr     = lat_addr;
                    if (cnt == 2'd0) begin
                        state_next = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    mem_we     = 1'b1;
                    mem_wdata  = merged;
                    mem_addr   = lat_addr;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State register plus the store context captured at detect and the merged word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lat_addr  <= '0;
            lat_lane  <= 2'd0;
            lat_half  <= 1'b0;
            lat_wdata <= 16'd0;
            merged    <= 32'd0;
            cnt       <= 2'd0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_addr  <= aligned;
                        lat_lane  <= ex_mem_addr[1:0];
                        lat_half  <= is_sh;
                        lat_wdata <= ex_mem_wdata[15:0];
                        cnt       <= CNT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        merged <= merge_word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subword_store_rmw.sv
// Testbench for subword_store_rmw: instance 0 uses READ_LATENCY=1, instance 1
// uses READ_LATENCY=3. Each has its own word memory with a read delay line.
module tb_subword_store_rmw;

    logic              clk = 1'b0;
    logic [1:0]        rst_n = 2'b00;
    logic [1:0]        memwrite = 2'b00;
    logic [1:0]        memread = 2'b00;
    logic [1:0][2:0]   funct3 = '0;
    logic [1:0][31:0]  ex_addr = '0;
    logic [1:0][31:0]  ex_wdata = '0;
    logic [1:0][31:0]  mem_rdata;
    logic [1:0][31:0]  mem_addr;
    logic [1:0][31:0]  mem_wdata;
    logic [1:0]        mem_we;
    logic [1:0]        mem_re;
    logic [1:0]        mem_bh;
    logic [1:0]        mis_err;

    logic [1:0]        pre_en = 2'b00;
    logic [5:0]        pre_idx = '0;
    logic [31:0]       pre_val = '0;

    logic [31:0]       mem     [2][64];
    logic [31:0]       ref_mem [2][64];
    logic [31:0]       pipe    [2][4];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sbq0[$];
    exp_t sbq1[$];

    typedef struct {
        int          sel;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_word;
        int          exp_stall;
        int          exp_mis;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    subword_store_rmw #(.ADDR_W(32), .READ_LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .ex_mem_memwrite(memwrite[0]), .ex_mem_memread(memread[0]),
        .ex_mem_funct3(funct3[0]), .ex_mem_addr(ex_addr[0]), .ex_mem_wdata(ex_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_write_bh(mem_bh[0]),
        .misalign_err(mis_err[0])
    );

    subword_store_rmw #(.ADDR_W(32), .READ_LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .ex_mem_memwrite(memwrite[1]), .ex_mem_memread(memread[1]),
        .ex_mem_funct3(funct3[1]), .ex_mem_addr(ex_addr[1]), .ex_mem_wdata(ex_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_write_bh(mem_bh[1]),
        .misalign_err(mis_err[1])
    );

    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    // Word memories: write port, bench preload port and a read delay line each.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_we[k]) mem[k][mem_addr[k][7:2]] <= mem_wdata[k];
            else if (pre_en[k]) mem[k][pre_idx] <= pre_val;
            pipe[k][0] <= mem_re[k] ? mem[k][mem_addr[k][7:2]] : 32'h0;
            for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Scoreboard: every memory write is popped against the expected queue.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (mem_we[k] && mem_re[k]) checkOutput("we_re_exclusive", 32'd1, 32'd0);
            if (mem_we[k]) begin
                if ((k == 0 && sbq0.size() == 0) || (k == 1 && sbq1.size() == 0)) begin
                    checkOutput("unexpected_write", mem_addr[k], 32'hFFFF_FFFF);
                end else begin
                    e = (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    checkOutput("write_addr", mem_addr[k], e.addr);
                    checkOutput("write_data", mem_wdata[k], e.data);
                end
            end
        end
    end

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                                input logic [31:0] addr, input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] src;
        logic [31:0] res;
        case (f3)
            3'b000:  begin be = 4'b0001 << addr[1:0]; src = {4{wd[7:0]}}; end
            3'b001:  begin be = addr[1] ? 4'b1100 : 4'b0011; src = {2{wd[15:0]}}; end
            default: begin be = 4'b1111; src = wd; end
        endcase
        for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? src[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    task automatic preload(input int k, input logic [5:0] idx, input logic [31:0] val);
        pre_en[k] = 1'b1;
        pre_idx   = idx;
        pre_val   = val;
        ref_mem[k][idx] = val;
        @(posedge clk); #1;
        pre_en[k] = 1'b0;
    endtask

    task automatic idleInputs(input int k);
        memwrite[k] = 1'b0;
        memread[k]  = 1'b0;
    endtask

    // Drive one store (called just after a rising edge), hold it while stalled,
    // and return just after the edge on which it leaves MEM.
    task automatic applyStimulus(input int k, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output int stall, output int mis);
        exp_t e;
        bit   done;
        if (!(f3 == 3'b001 && addr[0])) begin
            e.addr = {addr[31:2], 2'b00};
            e.data = model_store(ref_mem[k][addr[7:2]], f3, addr, wd);
            ref_mem[k][addr[7:2]] = e.data;
            if (k == 0) sbq0.push_back(e); else sbq1.push_back(e);
        end
        funct3[k]   = f3;
        ex_addr[k]  = addr;
        ex_wdata[k] = wd;
        memwrite[k] = 1'b1;
        memread[k]  = 1'b0;
        stall = 0;
        mis   = 0;
        done  = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (mis_err[k]) mis++;
            if (mem_bh[k]) stall++;
            else done = 1'b1;
        end
        if (!done) checkOutput("stall_timeout", 32'(stall), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int stall;
        int mis;
        vecs[0] = '{0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0};
        vecs[1] = '{0, 3'b000, 32'h12, 32'h000000AA, 32'h11223344, 32'h11AA3344, 2, 0};
        vecs[2] = '{0, 3'b001, 32'h22, 32'h0000BEEF, 32'h11223344, 32'hBEEF3344, 2, 0};
        vecs[3] = '{0, 3'b001, 32'h20, 32'h0000BEEF, 32'h11223344, 32'h1122BEEF, 2, 0};
        vecs[4] = '{0, 3'b001, 32'h21, 32'h0000BEEF, 32'h11223344, 32'h11223344, 0, 1};
        vecs[5] = '{1, 3'b000, 32'h13, 32'h00000077, 32'h11223344, 32'h77223344, 4, 0};
        vecs[6] = '{0, 3'b000, 32'h01, 32'h12345678, 32'hFFFFFFFF, 32'hFFFF78FF, 2, 0};
        vecs[7] = '{1, 3'b001, 32'h2A, 32'hCAFE1234, 32'h0,        32'h12340000, 4, 0};
        vecs[8] = '{0, 3'b011, 32'h33, 32'h01020304, 32'h0,        32'h01020304, 0, 0};

        // Reset: a pending SB must not raise the stall or touch memory.
        funct3[0]   = 3'b000;
        ex_addr[0]  = 32'h10;
        memwrite[0] = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_we", 32'(mem_we[k]), 32'd0);
            checkOutput("reset_re", 32'(mem_re[k]), 32'd0);
            checkOutput("reset_bh", 32'(mem_bh[k]), 32'd0);
            checkOutput("reset_addr", mem_addr[k], 32'd0);
        end
        idleInputs(0);
        @(posedge clk); #1;
        rst_n = 2'b11;
        @(posedge clk); #1;

        // Load passes through without a stall.
        memread[0] = 1'b1;
        ex_addr[0] = 32'h15;
        @(negedge clk);
        checkOutput("load_re", 32'(mem_re[0]), 32'd1);
        checkOutput("load_addr", mem_addr[0], 32'h14);
        checkOutput("load_bh", 32'(mem_bh[0]), 32'd0);
        @(posedge clk); #1;
        idleInputs(0);

        for (int i = 0; i < 9; i++) begin
            preload(vecs[i].sel, vecs[i].addr[7:2], vecs[i].init);
            applyStimulus(vecs[i].sel, vecs[i].f3, vecs[i].addr, vecs[i].wdata, stall, mis);
            idleInputs(vecs[i].sel);
            checkOutput($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            checkOutput($sformatf("vec%0d_mis", i), 32'(mis), 32'(vecs[i].exp_mis));
            checkOutput($sformatf("vec%0d_word", i), mem[vecs[i].sel][vecs[i].addr[7:2]], vecs[i].exp_word);
        end

        // Back-to-back SB: the second read must see the first write.
        preload(0, 6'd4, 32'h0);
        applyStimulus(0, 3'b000, 32'h10, 32'h55, stall, mis);
        checkOutput("b2b_stall1", 32'(stall), 32'd2);
        applyStimulus(0, 3'b000, 32'h11, 32'h66, stall, mis);
        idleInputs(0);
        checkOutput("b2b_stall2", 32'(stall), 32'd2);
        checkOutput("b2b_word", mem[0][4], 32'h00006655);

        // Reset in WAIT aborts the write and zeroes outputs at once.
        preload(1, 6'd4, 32'h11223344);
        funct3[1]   = 3'b000;
        ex_addr[1]  = 32'h13;
        ex_wdata[1] = 32'h77;
        memwrite[1] = 1'b1;
        @(negedge clk);
        checkOutput("abort_detect_bh", 32'(mem_bh[1]), 32'd1);
        @(negedge clk);
        checkOutput("abort_wait_bh", 32'(mem_bh[1]), 32'd1);
        rst_n[1] = 1'b0;
        #1;
        checkOutput("abort_bh", 32'(mem_bh[1]), 32'd0);
        checkOutput("abort_we", 32'(mem_we[1]), 32'd0);
        checkOutput("abort_addr", mem_addr[1], 32'd0);
        idleInputs(1);
        repeat (3) @(posedge clk);
        #1 rst_n[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort_word", mem[1][4], 32'h11223344);

        checkOutput("sbq0_empty", 32'(sbq0.size()), 32'd0);
        checkOutput("sbq1_empty", 32'(sbq1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/subword_store_rmw.md
Name: subword_store_rmw

Overview:
- Executes SB/SH stores as a read-modify-write sequence on a word-only data memory.
- Sits in the MEM stage between the EX/MEM pipeline register and the data-memory port.
- Drives mem_write_bh, the stall request consumed by the hazard unit.
- Full-word stores (SW) and loads pass straight through with no stall.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- READ_LATENCY, 1, cycles from mem_re to valid mem_rdata; legal values 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_mem_memwrite  in  1  store instruction present in MEM stage.
- ex_mem_memread  in  1  load instruction present in MEM stage.
- ex_mem_funct3  in  3  000=SB, 001=SH, 010=SW; other codes are treated as SW.
- ex_mem_addr  in  ADDR_W  byte address.
- ex_mem_wdata  in  32  rs2 value; the low byte/half is used for SB/SH.
- mem_rdata  in  32  word read data.
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits always 0).
- mem_wdata  out  32  word write data.
- mem_we  out  1  word write strobe.
- mem_re  out  1  word read strobe.
- mem_write_bh  out  1  stall request to the hazard unit (freezes PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- misalign_err  out  1  one-cycle pulse: SH with addr[0]=1.

Behaviour:
- States: IDLE, WAIT, WRITE.
- Reset (async, rst_n=0):
  - state=IDLE; latched addr/data/size cleared; wait counter=0.
  - All outputs 0; mem_we and mem_write_bh forced 0 immediately, so no partial write is ever issued.
- IDLE:
  - Outputs are combinational from the ex_mem_* inputs.
  - SW: mem_we=1, mem_wdata=ex_mem_wdata, mem_addr={addr[ADDR_W-1:2],2'b00}, no stall.
  - Load: mem_re=1, same address, no stall.
  - SB, or SH with addr[0]=0: mem_re=1 at the aligned address; mem_write_bh=1 (combinational, same cycle); latch addr[1:0], funct3, wdata, aligned address; counter=READ_LATENCY-1; next state=WAIT.
  - SH with addr[0]=1: misalign_err=1 for that cycle, store dropped (mem_we=0, mem_re=0, no stall), stay in IDLE.
- WAIT:
  - mem_write_bh=1; mem_re=0; mem_addr holds the latched address.
  - Counter decrements each cycle.
  - In the cycle counter==0, mem_rdata is valid: merge and register the word, next state=WRITE.
- Merge rules (little-endian):
  - SB lane k=addr[1:0]: byte k ← wdata[7:0], other bytes kept from mem_rdata.
  - SH addr[1]=0: bytes 1:0 ← wdata[15:0]; addr[1]=1: bytes 3:2 ← wdata[15:0]; other bytes kept.
- WRITE:
  - mem_we=1, mem_wdata=merged word, mem_addr=latched address.
  - mem_write_bh=0, so the pipeline advances this cycle and the store leaves MEM.
  - Next state=IDLE unconditionally.
  - The instruction entering MEM is first evaluated in the following IDLE cycle; it cannot be re-triggered by the departing store.
- Stall length: mem_write_bh is high for exactly READ_LATENCY+1 consecutive cycles per SB/SH. The store's write lands in cycle READ_LATENCY+1 counted from the detect cycle.
- Back-to-back SB/SH: the second is detected in the IDLE cycle after WRITE. Its read observes the first store's write (memory write-then-read ordering across cycles).
- Inputs ex_mem_* are ignored outside IDLE; they are frozen by the stall anyway.
- Reset asserted in WAIT or WRITE: sequence aborted, no write; the memory word keeps its old value.
- mem_we and mem_re are never both 1 in the same cycle.

Test Plan:
- Reset, then SW addr=0x10 data=0xDEADBEEF → same cycle: mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, mem_write_bh=0.
- Memory[0x10]=0x11223344; SB addr=0x12 data=0x000000AA (READ_LATENCY=1) → mem_write_bh=1 for 2 cycles; third cycle mem_we=1, mem_wdata=0x11AA3344, mem_write_bh=0.
- Memory[0x20]=0x11223344; SH addr=0x22 data=0x0000BEEF → write 0xBEEF3344. SH addr=0x20 → write 0x1122BEEF.
- SH addr=0x21 → misalign_err pulses 1 cycle; mem_we=0, mem_write_bh=0; memory unchanged.
- SB addr=0x10 immediately followed by SB addr=0x11 (data 0x55 then 0x66, initial 0x00000000) → two 2-cycle stalls; final memory word 0x00006655.
- READ_LATENCY=3, SB addr=0x13 data=0x77 → stall 4 cycles, write 0x77223344. Repeat with rst_n pulsed low in WAIT → mem_we never asserted, outputs 0 at once, word still 0x11223344.
